// File: rtl/axis_dma_rx_engine.sv
// Memory-to-stream DMA engine: fetches fixed-size packets from SRAM with one AXI4
// INCR read burst per packet and emits each packet as a single AXI-Stream word.
module axis_dma_rx_engine #(
    parameter int AXI_ADDR_W    = 64,
    parameter int AXI_DATA_W    = 64,
    parameter int AXI_ID_W      = 4,
    parameter int BEATS_PER_PKT = 4,
    parameter int AXIS_W        = AXI_DATA_W * BEATS_PER_PKT,
    parameter int RD_ID         = 0
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [AXI_ADDR_W-1:0] src_addr,
    input  logic [31:0]           len_pkts,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [AXI_ID_W-1:0]   ar_id,
    output logic [AXI_ADDR_W-1:0] ar_addr,
    output logic [7:0]            ar_len,
    output logic [2:0]            ar_size,
    output logic [1:0]            ar_burst,
    output logic                  ar_valid,
    input  logic                  ar_ready,
    input  logic [AXI_ID_W-1:0]   r_id,
    input  logic [AXI_DATA_W-1:0] r_data,
    input  logic [1:0]            r_resp,
    input  logic                  r_last,
    input  logic                  r_valid,
    output logic                  r_ready,
    output logic [AXIS_W-1:0]     m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready
);
    localparam int STRIDE   = BEATS_PER_PKT * AXI_DATA_W / 8;
    localparam int ADDR_LSB = $clog2(STRIDE);
    localparam int BEAT_W   = (BEATS_PER_PKT > 1) ? $clog2(BEATS_PER_PKT) : 1;
    localparam logic [AXI_ADDR_W-1:0] ADDR_MASK  = (AXI_ADDR_W'(1) << ADDR_LSB) - AXI_ADDR_W'(1);
    localparam logic [AXI_ADDR_W-1:0] STRIDE_INC = AXI_ADDR_W'(STRIDE);
    localparam logic [BEAT_W-1:0]     LAST_BEAT  = BEAT_W'(BEATS_PER_PKT - 1);
    localparam logic [AXI_ID_W-1:0]   ID_VAL     = AXI_ID_W'(RD_ID);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    state_t                state_r;
    logic [AXI_ADDR_W-1:0] addr_r;
    logic [31:0]           len_r;
    logic [31:0]           pkt_cnt_r;
    logic [BEAT_W-1:0]     beat_cnt_r;
    logic [AXIS_W-1:0]     data_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  err_r;
    logic                  ar_valid_r;
    logic                  r_ready_r;
    logic                  tvalid_r;
    logic [AXI_ID_W-1:0]   ar_id_r;
    logic [7:0]            ar_len_r;
    logic [2:0]            ar_size_r;
    logic [1:0]            ar_burst_r;

    logic                  beat_acc_s;
    logic                  last_beat_s;
    logic                  beat_bad_s;
    logic                  pkt_acc_s;
    logic [31:0]           pkt_next_s;
    logic                  final_pkt_s;

    // Handshake decodes and per-beat protocol check (beat counter, not r_last, decides framing)
    always_comb begin
        beat_acc_s  = r_valid & r_ready_r;
        last_beat_s = (beat_cnt_r == LAST_BEAT);
        beat_bad_s  = (r_resp != 2'b00) | (r_id != ID_VAL) | (r_last != last_beat_s);
        pkt_acc_s   = tvalid_r & m_axis_tready;
        pkt_next_s  = pkt_cnt_r + 32'd1;
        final_pkt_s = (pkt_next_s == len_r);
    end

    // Transfer sequencer: state, counters, packet assembly and every output register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r    <= ST_IDLE;
            addr_r     <= '0;
            len_r      <= 32'd0;
            pkt_cnt_r  <= 32'd0;
            beat_cnt_r <= '0;
            data_r     <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            ar_valid_r <= 1'b0;
            r_ready_r  <= 1'b0;
            tvalid_r   <= 1'b0;
            ar_id_r    <= '0;
            ar_len_r   <= 8'd0;
            ar_size_r  <= 3'd0;
            ar_burst_r <= 2'b00;
        end else begin
            ar_id_r    <= ID_VAL;
            ar_len_r   <= 8'(BEATS_PER_PKT - 1);
            ar_size_r  <= 3'($clog2(AXI_DATA_W / 8));
            ar_burst_r <= 2'b01;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        err_r <= 1'b0;
                        if (len_pkts != 32'd0) begin
                            addr_r     <= src_addr & ~ADDR_MASK;
                            len_r      <= len_pkts;
                            pkt_cnt_r  <= 32'd0;
                            done_r     <= 1'b0;
                            busy_r     <= 1'b1;
                            ar_valid_r <= 1'b1;
                            state_r    <= ST_AR;
                        end else begin
                            done_r <= 1'b1;
                        end
                    end
                end
                ST_AR: begin
                    if (ar_ready) begin
                        ar_valid_r <= 1'b0;
                        r_ready_r  <= 1'b1;
                        beat_cnt_r <= '0;
                        state_r    <= ST_R;
                    end
                end
                ST_R: begin
                    if (beat_acc_s) begin
                        for (int b = 0; b < BEATS_PER_PKT; b++) begin
                            if (beat_cnt_r == BEAT_W'(b)) begin
                                data_r[b*AXI_DATA_W +: AXI_DATA_W] <= r_data;
                            end
                        end
                        if (beat_bad_s) begin
                            err_r <= 1'b1;
                        end
                        beat_cnt_r <= beat_cnt_r + BEAT_W'(1);
                        if (last_beat_s) begin
                            r_ready_r <= 1'b0;
                            tvalid_r  <= 1'b1;
                            state_r   <= ST_OUT;
                        end
                    end
                end
                ST_OUT: begin
                    if (pkt_acc_s) begin
                        tvalid_r  <= 1'b0;
                        pkt_cnt_r <= pkt_next_s;
                        addr_r    <= addr_r + STRIDE_INC;
                        if (final_pkt_s) begin
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            state_r <= ST_IDLE;
                        end else begin
                            ar_valid_r <= 1'b1;
                            state_r    <= ST_AR;
                        end
                    end
                end
                default: begin
                    busy_r     <= 1'b0;
                    ar_valid_r <= 1'b0;
                    r_ready_r  <= 1'b0;
                    tvalid_r   <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy          = busy_r;
    assign done          = done_r;
    assign err           = err_r;
    assign ar_id         = ar_id_r;
    assign ar_addr       = addr_r;
    assign ar_len        = ar_len_r;
    assign ar_size       = ar_size_r;
    assign ar_burst      = ar_burst_r;
    assign ar_valid      = ar_valid_r;
    assign r_ready       = r_ready_r;
    assign m_axis_tdata  = data_r;
    assign m_axis_tvalid = tvalid_r;

endmodule
